// File: rtl/am_demod_post.sv
// Post-FIR AM demod stage: scale/saturate to 16 bits, remove DC, decimate, buffer.
// Latency 3 cycles input-to-output; no input backpressure, excess samples drop to sticky overflow.

// Small valid/ready FIFO whose push is allowed when full only if a pop happens the same edge.
// Latency: written data visible at the head one cycle after the push edge.
// Backpressure: a push into a full FIFO without a pop is discarded and flagged on drop_o.
module am_demod_post_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         rdy_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic         drop_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop, do_push, full;

    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = rdy_i && (cnt_q != '0);
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;
    assign vld_o   = (cnt_q != '0);
    assign dat_o   = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // When full and popping, the write slot equals the slot being read out this edge.
            if (do_push) begin
                mem_q[wr_ptr_q] <= dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

// AM demodulator post-processing: >>>SHIFT + sat16, block-average DC removal, 1-in-DEC decimation.
// Latency: 3 cycles from in_valid to out_valid with the output FIFO empty.
// Backpressure: 4-deep FIFO on out_ready; a decimated sample arriving to a full FIFO sets overflow.
module am_demod_post #(
    parameter int SHIFT    = 20,
    parameter int AVG_LOG2 = 10,
    parameter int DEC      = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [15:0] dc_level,
    output logic        overflow
);
    localparam int AW = 16 + AVG_LOG2;

    logic signed [47:0]    t;
    logic signed [15:0]    x_q, x_d, dc_q, dc_d, y_q, y_d;
    logic                  xv_q, yv_q, overflow_q;
    logic signed [AW-1:0]  acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0]   wcnt_q, wcnt_d;
    logic signed [16:0]    diff;
    logic [3:0]            phase_q, phase_d;
    logic                  push, drop;

    assign t = $signed(in_data) >>> SHIFT;

    always_comb begin
        x_d = t[15:0];
        if (t > 48'sd32767) x_d = 16'sh7fff;
        else if (t < -48'sd32768) x_d = 16'sh8000;
    end

    // DC window: the terminal sample is folded into the average, then the window restarts.
    assign sum = acc_q + AW'(x_q);

    always_comb begin
        acc_d  = acc_q;
        wcnt_d = wcnt_q;
        dc_d   = dc_q;
        if (xv_q) begin
            if (&wcnt_q) begin
                dc_d   = 16'(sum >>> AVG_LOG2);
                acc_d  = '0;
                wcnt_d = '0;
            end else begin
                acc_d  = sum;
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    // Uses the DC estimate held before this edge, so a same-edge update applies from the next x.
    assign diff = 17'(x_q) - 17'(dc_q);

    always_comb begin
        y_d = diff[15:0];
        if (diff > 17'sd32767) y_d = 16'sh7fff;
        else if (diff < -17'sd32768) y_d = 16'sh8000;
    end

    assign push = yv_q && (phase_q == 4'd0);

    always_comb begin
        phase_d = phase_q;
        if (yv_q) phase_d = (phase_q == 4'(DEC - 1)) ? 4'd0 : phase_q + 4'd1;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            x_q        <= '0;
            xv_q       <= 1'b0;
            acc_q      <= '0;
            wcnt_q     <= '0;
            dc_q       <= '0;
            y_q        <= '0;
            yv_q       <= 1'b0;
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (in_valid) x_q <= x_d;
            xv_q   <= in_valid;
            acc_q  <= acc_d;
            wcnt_q <= wcnt_d;
            dc_q   <= dc_d;
            if (xv_q) y_q <= y_d;
            yv_q    <= xv_q;
            phase_q <= phase_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    am_demod_post_fifo #(.W(16), .DEPTH(4)) u_fifo (
        .clk_in (clk_in),
        .rst    (rst),
        .push_i (push),
        .dat_i  (y_q),
        .rdy_i  (out_ready),
        .vld_o  (out_valid),
        .dat_o  (out_data),
        .drop_o (drop)
    );

    assign dc_level = dc_q;
    assign overflow = overflow_q;
endmodule
